// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding, mul/div op codes and the
// decode-stage function codes.
package alu_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam logic [3:0] FNC_ADD = 4'h8;
    localparam logic [3:0] FNC_SUB = 4'h9;
    localparam logic [3:0] FNC_MUL = 4'hA;
    localparam logic [3:0] FNC_DIV = 4'hB;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring shift-subtract divide.
module muldiv_step
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             op,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] opr,
    input  logic [WIDTH-1:0] oper,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] opr_nxt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    always_comb begin
        sum    = {1'b0, acc} + (opr[0] ? {1'b0, oper} : '0);
        rem_sh = {acc, opr[WIDTH-1]};
        trial  = rem_sh - {1'b0, oper};
        if (op == OP_MUL) begin
            // carry out of the adder shifts into the top of the accumulator
            acc_nxt = sum[WIDTH:1];
            opr_nxt = {sum[0], opr[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
            acc_nxt = trial[WIDTH-1:0];
            opr_nxt = {opr[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt = rem_sh[WIDTH-1:0];
            opr_nxt = {opr[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle multiply/divide sequencer; stalls the CPU via busy and returns
// a 64-bit result (low word / quotient, high word / remainder).
//
// state | meaning
// IDLE  | waiting for start; operands latched on start
// PREP  | take magnitudes, record signs, load accumulator
// ITER  | WIDTH shift-add / shift-subtract steps
// FIX   | apply signs, floor correction, divide-by-zero override
// DONE  | done pulse, results valid
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic             uns,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic             op_q, uns_q, neg_x, neg_y;
    logic [WIDTH-1:0] op1_q, op2_q;
    logic [WIDTH-1:0] acc, opr, oper;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0]   abs1, abs2, acc_nxt, opr_nxt, q_fix, r_fix;
    logic [2*WIDTH-1:0] prod, prod_fix;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op      (op_q),
        .acc     (acc),
        .opr     (opr),
        .oper    (oper),
        .acc_nxt (acc_nxt),
        .opr_nxt (opr_nxt)
    );

    // 0x80000000 maps onto itself, which reads correctly as an unsigned magnitude
    assign abs1 = (!uns_q && op1_q[WIDTH-1]) ? -op1_q : op1_q;
    assign abs2 = (!uns_q && op2_q[WIDTH-1]) ? -op2_q : op2_q;

    always_comb begin
        prod     = {acc, opr};
        prod_fix = (!uns_q && (neg_x ^ neg_y)) ? -prod : prod;
        q_fix    = opr;
        r_fix    = acc;
        if (!uns_q) begin
            if (neg_x ^ neg_y) q_fix = -opr;
            if (neg_x)         r_fix = -acc;
            if (r_fix != '0 && r_fix[WIDTH-1] != op2_q[WIDTH-1]) begin
                q_fix = q_fix - WIDTH'(1);
                r_fix = r_fix + op2_q;
            end
        end
        if (op2_q == '0) begin
            q_fix = '1;
            r_fix = op1_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            op_q   <= 1'b0;
            uns_q  <= 1'b0;
            neg_x  <= 1'b0;
            neg_y  <= 1'b0;
            op1_q  <= '0;
            op2_q  <= '0;
            acc    <= '0;
            opr    <= '0;
            oper   <= '0;
            cnt    <= '0;
            res_lo <= '0;
            res_hi <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        uns_q <= uns;
                        op1_q <= op1;
                        op2_q <= op2;
                        busy  <= 1'b1;
                        state <= S_PREP;
                    end
                end
                S_PREP: begin
                    neg_x <= !uns_q && op1_q[WIDTH-1];
                    neg_y <= !uns_q && op2_q[WIDTH-1];
                    acc   <= '0;
                    opr   <= (op_q == OP_MUL) ? abs2 : abs1;
                    oper  <= (op_q == OP_MUL) ? abs1 : abs2;
                    cnt   <= '0;
                    state <= S_ITER;
                end
                S_ITER: begin
                    acc <= acc_nxt;
                    opr <= opr_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
                end
                S_FIX: begin
                    if (op_q == OP_MUL) begin
                        {res_hi, res_lo} <= prod_fix;
                    end else begin
                        res_lo <= q_fix;
                        res_hi <= r_fix;
                    end
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomised + directed bench for alu_muldiv_seq against an arithmetic model.
module tb_alu_muldiv_seq;

    localparam int W = 32;
    localparam int LAT = W + 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic         uns = 1'b0;
    logic [W-1:0] op1 = '0;
    logic [W-1:0] op2 = '0;
    logic [W-1:0] res_lo, res_hi;
    logic         busy, done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq #(.WIDTH(W), .CNT_W(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .uns    (uns),
        .op1    (op1),
        .op2    (op2),
        .res_lo (res_lo),
        .res_hi (res_hi),
        .busy   (busy),
        .done   (done)
    );

    function automatic logic [63:0] ref_calc(input logic o, input logic u,
                                             input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o == 1'b0) begin
            if (u) p = {32'b0, a} * {32'b0, b};
            else   p = sa * sb;
            return p;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (u) return {a % b, a / b};
        q = sa / sb;
        if ((sa % sb) != 0 && ((sa < 0) != (sb < 0))) q = q - 1;
        r = sa - q * sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // model: an accepted start owns the next LAT cycles; result appears in the last one
    int          rem = 0;
    logic [63:0] pending = '0;
    logic [63:0] exp_res = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem = 0;
            exp_res = '0;
        end else if (rem == 0) begin
            if (start) begin
                rem = LAT;
                pending = ref_calc(op, uns, op1, op2);
            end
        end else begin
            rem--;
            if (rem == 1) exp_res = pending;
        end
    end

    always @(negedge clk) begin
        chk("busy",   {63'b0, busy}, {63'b0, rem != 0});
        chk("done",   {63'b0, done}, {63'b0, rem == 1});
        chk("res_lo", {32'b0, res_lo}, {32'b0, exp_res[31:0]});
        chk("res_hi", {32'b0, res_hi}, {32'b0, exp_res[63:32]});
    end

    task automatic run_op(input logic o, input logic u, input logic [31:0] a,
                          input logic [31:0] b, input bit pulse_mid,
                          input logic [63:0] lit, input string nm);
        int n, bc;
        @(negedge clk);
        op = o; uns = u; op1 = a; op2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = $urandom_range(0, 1); op1 = $urandom; op2 = $urandom;
        n = 1;
        bc = 0;
        while (1) begin
            if (busy) bc++;
            if (done || n >= 100) break;
            if (pulse_mid && n == 12) begin
                start = 1'b1; op1 = 32'h5; op2 = 32'h7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk({nm, " latency"}, 64'(n), 64'(LAT));
        chk({nm, " busy_cycles"}, 64'(bc), 64'(LAT));
        chk({nm, " result"}, {res_hi, res_lo}, lit);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dn;
        repeat (2) @(negedge clk);
        chk("reset busy", {63'b0, busy}, 64'd0);
        chk("reset res", {res_hi, res_lo}, 64'd0);
        rst = 1'b1;

        chk("model umul", ref_calc(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        chk("model smul", ref_calc(0, 0, -32'd3, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
        chk("model sdiv", ref_calc(1, 0, -32'd7, 32'd2), 64'h0000_0001_FFFF_FFFC);
        chk("model div0", ref_calc(1, 0, 32'd1234, 32'd0), 64'h0000_04D2_FFFF_FFFF);

        run_op(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 64'hFFFF_FFFE_0000_0001, "umul max");
        run_op(0, 0, -32'd3, 32'd5, 0, 64'hFFFF_FFFF_FFFF_FFF1, "smul -3*5");
        run_op(0, 0, 32'h8000_0000, 32'h8000_0000, 0, 64'h4000_0000_0000_0000, "smul minneg");
        run_op(1, 0, -32'd7, 32'd2, 0, 64'h0000_0001_FFFF_FFFC, "sdiv -7/2");
        run_op(1, 0, 32'd7, -32'd2, 0, 64'hFFFF_FFFF_FFFF_FFFC, "sdiv 7/-2");
        run_op(1, 0, 32'd6, 32'd3, 0, 64'h0000_0000_0000_0002, "sdiv 6/3");
        run_op(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 64'h0000_0000_8000_0000, "sdiv minneg/-1");
        run_op(1, 1, 32'hFFFF_FFFF, 32'd16, 0, 64'h0000_000F_0FFF_FFFF, "udiv /16");
        run_op(1, 0, 32'd1234, 32'd0, 0, 64'h0000_04D2_FFFF_FFFF, "sdiv by 0");
        run_op(1, 1, 32'd1234, 32'd0, 0, 64'h0000_04D2_FFFF_FFFF, "udiv by 0");
        run_op(0, 1, 32'd1000, 32'd3000, 1, 64'h0000_0000_002D_C6C0, "start mid-iter");

        // abort in ITER step 10
        @(negedge clk);
        op = 0; uns = 1; op1 = 32'hFFFF_FFFF; op2 = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort busy", {63'b0, busy}, 64'd0);
        chk("abort done", {63'b0, done}, 64'd0);
        chk("abort res", {res_hi, res_lo}, 64'd0);
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort no done", 64'(dn), 64'd0);
        rst = 1'b1;
        run_op(0, 0, 32'd7, -32'd6, 0, 64'hFFFF_FFFF_FFFF_FFD6, "after abort");

        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 7) == 0);
            op    = $urandom_range(0, 1);
            uns   = $urandom_range(0, 1);
            op1   = pick();
            op2   = pick();
        end
        @(negedge clk);
        start = 1'b0;
        repeat (LAT + 2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
